tc_call_stack: RTL
==================

Name: tc_call_stack

Overview:
- Control stage directly upstream of the program counter. Drives the counter's `save` and `in` ports.
- Turns per-cycle call / return / jump requests into PC load commands.
- Keeps a hardware return-address stack of `DEPTH` entries.
- On call, pushes the return address (current PC plus `RET_OFFSET`); on return, pops it back into the counter.

Parameters:
- BIT_WIDTH, 8, width of addresses; must match the counter's BIT_WIDTH.
- DEPTH, 8, number of return-address entries; must be >= 2.
- RET_OFFSET, 1, added to `pc` to form the pushed return address; must match the counter's step.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- pc  input  BIT_WIDTH  current counter output (address being executed).
- call  input  1  push (`pc`+RET_OFFSET) and load `target`.
- ret  input  1  pop the top entry and load it.
- jump  input  1  load `target` without touching the stack.
- target  input  BIT_WIDTH  destination for call/jump.
- clr_err  input  1  clear the sticky error flags.
- save  output  1  to counter `save`.
- addr  output  BIT_WIDTH  to counter `in`.
- depth  output  $clog2(DEPTH+1)  number of valid entries.
- empty  output  1  depth==0.
- full  output  1  depth==DEPTH.
- overflow  output  1  sticky: a call was attempted while full.
- underflow  output  1  sticky: a ret was attempted while empty.
- conflict  output  1  sticky: more than one of call/ret/jump was high in the same cycle.

Behaviour:
- **Reset:** `rst` sampled at the posedge clears `depth`, `overflow`, `underflow` and `conflict`; `empty`=1, `full`=0. Stack RAM contents are don't-care. Reset has priority over all requests in that cycle, and no push/pop occurs.
- **save/addr timing:** combinational from the inputs and the registered stack top (zero-latency, matching the counter's same-edge load). The counter loads `addr` at the same edge where the stack updates.
- **Priority:** ret > call > jump. If two or more are high, only the highest acts and `conflict` is set at that edge.
- **ret:**
  - depth>0: save=1, addr=stack[depth-1]; at the edge depth decrements.
  - depth==0: save=0, addr=0, no state change except underflow<=1.
- **call:**
  - save=1, addr=target, regardless of fullness.
  - Not full: at the edge stack[depth] <= pc+RET_OFFSET (mod 2^BIT_WIDTH, wraps silently) and depth increments.
  - Full: no push; depth unchanged; overflow<=1. The jump to `target` still happens.
- **jump only:** save=1, addr=target, stack untouched.
- **No request:** save=0, addr=0.
- **clr_err:** clears all three sticky flags at the edge. A new error in the same cycle wins (flag ends 1).
- **Occupancy:** `depth` ranges over 0..DEPTH and never wraps. `full`/`empty` are decoded from registered `depth`, so they are glitch-free relative to the inputs.
- **Storage:** register array with write index depth and read index depth-1. No read-during-write hazard, because push and pop never coexist by the priority rule.
- **Reset during a long call chain:** all entries are lost and the next ret underflows.

Decomposition:
- Shared package `tc_ctrl_pkg`:
  - request priority encoding (enum REQ_NONE, REQ_JUMP, REQ_CALL, REQ_RET);
  - helper function for the depth-counter width ($clog2(DEPTH+1)).
- One natural sub-module: `tc_lifo_regs`, a parameterised register-array LIFO with push/pop/top/depth/full/empty.
- `tc_call_stack` wraps it with request decode, save/addr muxing and the sticky flags.

Test Plan:
- **Reset then idle:** rst=1 for 1 cycle, then no requests for 3 cycles -> save=0, depth=0, empty=1, all flags 0.
- **Call then return:**
  - pc=0x10, call=1, target=0x40 -> same cycle save=1, addr=0x40.
  - Next cycle depth=1.
  - Later ret=1 -> save=1, addr=0x11, then depth=0.
- **Nested calls:** 3 calls at pc=0x05, 0x42, 0x81 -> 3 rets return 0x82, 0x43, 0x06 in that order; empty=1 after.
- **Overflow (DEPTH=8):**
  - 8 calls -> full=1.
  - 9th call with target=0x20 -> save=1, addr=0x20, depth stays 8, overflow=1.
  - clr_err=1 -> overflow=0.
- **Underflow and wrap:**
  - ret on empty -> save=0, underflow=1.
  - call at pc=0xFF with BIT_WIDTH=8 -> pushed 0x00; subsequent ret gives addr=0x00.
- **Conflict and reset:**
  - call=1, ret=1 with depth=2 -> pop wins, addr=top, depth=1, conflict=1.
  - rst asserted together with call -> depth=0, no push, flags cleared.

Source files
------------

// File: rtl/tc_ctrl_pkg.sv
// Shared request encoding and sizing helpers for the PC control stage.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package tc_ctrl_pkg;

  // Request priority order: higher enum value wins when several are asserted.
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_JUMP = 2'd1,
    REQ_CALL = 2'd2,
    REQ_RET  = 2'd3
  } req_e;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int depth_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tc_lifo_regs.sv
// Register-array LIFO with push/pop, combinational top-of-stack and occupancy.
// Latency: top is combinational from registered state; push/pop take effect at the next edge.
// Backpressure: none; push when full and pop when empty are silently ignored.
module tc_lifo_regs
  import tc_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             push_dat,
  output logic [WIDTH-1:0]             top_dat,
  output logic [depth_w(DEPTH)-1:0]    depth,
  output logic                         full,
  output logic                         empty
);

  localparam int DW = depth_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DW-1:0]    depth_q;
  logic [DW-1:0]    depth_d;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  // Occupancy decode and indices: write slot is depth, top of stack is depth-1.
  always_comb begin
    full    = (depth_q == DW'(DEPTH));
    empty   = (depth_q == '0);
    wr_idx  = AW'(depth_q);
    rd_idx  = AW'(depth_q - DW'(1));
    top_dat = mem_q[rd_idx];
    depth   = depth_q;
  end

  // Next-state: a push into a free slot or a pop of a valid entry, never both at once.
  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (push && !full) begin
      mem_d[wr_idx] = push_dat;
      depth_d       = depth_q + DW'(1);
    end else if (pop && !empty) begin
      depth_d       = depth_q - DW'(1);
    end
  end

  // State registers; entry contents are left alone on reset since depth invalidates them.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/tc_call_stack.sv
// Call/return/jump decode feeding the program counter's save/in ports, with a return-address stack.
// Latency: save/addr are combinational (same-edge load); stack and flags update at the next edge.
// Backpressure: none; overflow/underflow/conflict are reported through sticky flags.
module tc_call_stack
  import tc_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH  = 8,
  parameter int DEPTH      = 8,
  parameter int RET_OFFSET = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BIT_WIDTH-1:0]         pc,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         jump,
  input  logic [BIT_WIDTH-1:0]         target,
  input  logic                         clr_err,
  output logic                         save,
  output logic [BIT_WIDTH-1:0]         addr,
  output logic [depth_w(DEPTH)-1:0]    depth,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         conflict
);

  req_e                 req;
  logic                 multi_req;
  logic                 push;
  logic                 pop;
  logic [BIT_WIDTH-1:0] ret_addr;
  logic [BIT_WIDTH-1:0] top_dat;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 cnf_q, cnf_d;

  tc_lifo_regs #(
    .WIDTH (BIT_WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_dat (ret_addr),
    .top_dat  (top_dat),
    .depth    (depth),
    .full     (full),
    .empty    (empty)
  );

  // Priority decode (ret > call > jump) and the counter load command.
  always_comb begin
    req       = REQ_NONE;
    save      = 1'b0;
    addr      = '0;
    push      = 1'b0;
    pop       = 1'b0;
    ret_addr  = pc + BIT_WIDTH'(RET_OFFSET);
    multi_req = (call & ret) | (call & jump) | (ret & jump);
    if (ret)       req = REQ_RET;
    else if (call) req = REQ_CALL;
    else if (jump) req = REQ_JUMP;
    case (req)
      REQ_RET: begin
        if (!empty) begin
          save = 1'b1;
          addr = top_dat;
          pop  = 1'b1;
        end
      end
      REQ_CALL: begin
        // The jump to target happens even when the stack cannot take the return address.
        save = 1'b1;
        addr = target;
        push = 1'b1;
      end
      REQ_JUMP: begin
        save = 1'b1;
        addr = target;
      end
      default: ;
    endcase
  end

  // Sticky error flags: clear request drops old errors, a fresh error in the same cycle survives.
  always_comb begin
    ovf_d = (ovf_q & ~clr_err) | ((req == REQ_CALL) & full);
    unf_d = (unf_q & ~clr_err) | ((req == REQ_RET) & empty);
    cnf_d = (cnf_q & ~clr_err) | multi_req;
  end

  // Flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      cnf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      cnf_q <= cnf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign conflict  = cnf_q;

endmodule
